bram_sdp_bytewr: RTL

// Parametrised simple-dual-port block RAM for BRISKI register files and scratch memories.

---
 rtl/bram_sdp_bytewr.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bram_sdp_bytewr.sv
// Simple-dual-port block RAM with byte-lane writes, 1- or 2-cycle read latency,
// optional write-to-read bypass and a post-reset zero-fill sequencer.
module bram_sdp_bytewr #(
    parameter int unsigned SIZE           = 512,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned BYPASS         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter string       RAM_STYLE_ATTR = "block"
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            dia,
    input  logic                             enb,
    input  logic [ADDR_WIDTH-1:0]            addrb,
    output logic [DATA_WIDTH-1:0]            dob,
    output logic                             dob_valid,
    output logic                             init_busy
);

    localparam int unsigned NB        = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_W     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_lanes
        $error("bram_sdp_bytewr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_latency
        $error("bram_sdp_bytewr: READ_LATENCY must be 1 or 2");
    end
    if (64'(SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_chk_size
        $error("bram_sdp_bytewr: SIZE exceeds the address space");
    end
    if (RAM_STYLE_ATTR == "") begin : g_chk_style
        $error("bram_sdp_bytewr: RAM_STYLE_ATTR must not be empty");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    (* ram_style = RAM_STYLE_ATTR *)
    logic [DATA_WIDTH-1:0] mem [SIZE];

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                    init_busy_q, init_busy_d;

    logic                    wr_in_range_c;
    logic                    user_wr_c;
    logic                    mem_we_c;
    logic [IDX_W-1:0]        mem_idx_c;
    logic [NB-1:0]           mem_lanes_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;

    logic                    rd_accept_c;
    logic                    rd_in_range_c;
    logic                    rd_hit_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;

    // Clear sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q  <= '0;
            init_busy_q <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_busy_q <= init_busy_d;
        end
    end

    // One word zeroed per cycle; busy drops on the edge that writes the last word
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d  = clr_addr_q + ADDR_WIDTH'(1);
                init_busy_d = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d     = ST_READY;
                    clr_addr_d  = '0;
                    init_busy_d = 1'b0;
                end
            end
            ST_READY: begin
                init_busy_d = 1'b0;
            end
            default: begin
                state_d     = ST_READY;
                init_busy_d = 1'b0;
            end
        endcase
    end

    assign wr_in_range_c = (32'(addra) < SIZE);
    assign user_wr_c     = ena && !init_busy_q && wr_in_range_c && (|wea);

    // Write-port mux: the clear sequencer owns the port while busy
    always_comb begin
        mem_we_c    = user_wr_c;
        mem_idx_c   = IDX_W'(addra);
        mem_lanes_c = wea;
        mem_wdata_c = dia;
        if (init_busy_q) begin
            mem_we_c    = 1'b1;
            mem_idx_c   = IDX_W'(clr_addr_q);
            mem_lanes_c = '1;
            mem_wdata_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_lanes_c[i]) begin
                    mem[mem_idx_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_c[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rd_accept_c   = enb && !init_busy_q;
    assign rd_in_range_c = (32'(addrb) < SIZE);
    assign rd_hit_c      = (BYPASS != 0) && ena && !init_busy_q && wr_in_range_c && (addra == addrb);

    // Read word: out-of-range reads return zero; a same-address write overlays its lanes
    always_comb begin
        rd_word_c = '0;
        if (rd_in_range_c) begin
            rd_word_c = mem[IDX_W'(addrb)];
            if (rd_hit_c) begin
                for (int i = 0; i < NB; i++) begin
                    if (wea[i]) begin
                        rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = dia[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_accept_c;
            if (rd_accept_c) begin
                s1_data_q <= rd_word_c;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        // Output register advances only behind a valid first stage, so dob holds otherwise
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign dob       = s2_data_q;
        assign dob_valid = s2_valid_q;
    end else begin : g_lat1
        assign dob       = s1_data_q;
        assign dob_valid = s1_valid_q;
    end

    assign init_busy = init_busy_q;

endmodule
